oq_header_parser_mc: RTL and testbench

Parametrised output-queue header parser with multicast expansion. Watches the input packet stream, extracts destination mask, byte length and word length from the IOQ module header, and stores one descriptor per packet in an internal FIFO of configurable depth. The output side serialises a multi-bit destination mask into one descriptor per destination queue, lowest index first. It also flags malformed packets. It sits between the input arbiter stream and the BRAM output-queue store/scheduler.

---
 rtl/oq_header_parser_mc_if.sv | 46 ++++
 rtl/oq_header_parser_mc.sv | 202 ++++++++++++++++++++
 tb/tb_oq_header_parser_mc.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/oq_header_parser_mc_if.sv
`default_nettype none
// ============================================================================
// Module   : oq_header_parser_mc_if
// Purpose  : Packet stream input and descriptor output bundle for the
//            output-queue header parser.
// Revision : 1.0
// ============================================================================
interface oq_header_parser_mc_if #(
    parameter int DATA_WIDTH         = 64,
    parameter int CTRL_WIDTH         = DATA_WIDTH / 8,
    parameter int NUM_OUTPUT_QUEUES  = 8,
    parameter int NUM_OQ_WIDTH       = (NUM_OUTPUT_QUEUES > 1) ? $clog2(NUM_OUTPUT_QUEUES) : 1,
    parameter int PKT_BYTE_CNT_WIDTH = 11,
    parameter int PKT_WORD_CNT_WIDTH = 8,
    parameter int ERR_CNT_WIDTH      = 16
);
    logic                          in_wr;
    logic [CTRL_WIDTH-1:0]         in_ctrl;
    logic [DATA_WIDTH-1:0]         in_data;
    logic                          header_parser_rdy;
    logic                          desc_avail;
    logic                          rd_desc;
    logic [NUM_OQ_WIDTH-1:0]       desc_dst_oq;
    logic [NUM_OUTPUT_QUEUES-1:0]  desc_one_hot;
    logic [PKT_BYTE_CNT_WIDTH-1:0] desc_byte_len;
    logic [PKT_WORD_CNT_WIDTH-1:0] desc_word_len;
    logic                          desc_last;
    logic                          desc_drop;
    logic                          err_pulse;
    logic [ERR_CNT_WIDTH-1:0]      err_cnt;

    modport master (
        output in_wr, in_ctrl, in_data, rd_desc,
        input  header_parser_rdy, desc_avail, desc_dst_oq, desc_one_hot,
               desc_byte_len, desc_word_len, desc_last, desc_drop,
               err_pulse, err_cnt
    );

    modport slave (
        input  in_wr, in_ctrl, in_data, rd_desc,
        output header_parser_rdy, desc_avail, desc_dst_oq, desc_one_hot,
               desc_byte_len, desc_word_len, desc_last, desc_drop,
               err_pulse, err_cnt
    );
endinterface
`default_nettype wire

// File: rtl/oq_header_parser_mc.sv
`default_nettype none
// ============================================================================
// Module   : oq_header_parser_mc
// Purpose  : Extracts IOQ header fields into a descriptor FIFO and serves one
//            descriptor per destination queue when OQ_HDR_PARSER_MCAST_EN is
//            defined (one per packet otherwise); flags malformed packets.
// Revision : 1.0
// ============================================================================
module oq_header_parser_mc #(
    parameter int DATA_WIDTH         = 64,
    parameter int CTRL_WIDTH         = DATA_WIDTH / 8,
    parameter logic [CTRL_WIDTH-1:0] IOQ_STAGE_NUM = 8'hff,
    parameter int NUM_OUTPUT_QUEUES  = 8,
    parameter int NUM_OQ_WIDTH       = (NUM_OUTPUT_QUEUES > 1) ? $clog2(NUM_OUTPUT_QUEUES) : 1,
    parameter int DST_POS            = 48,
    parameter int BYTE_LEN_POS       = 0,
    parameter int WORD_LEN_POS       = 32,
    parameter int PKT_BYTE_CNT_WIDTH = 11,
    parameter int PKT_WORD_CNT_WIDTH = 8,
    parameter int DESC_DEPTH         = 8,
    parameter int ERR_CNT_WIDTH      = 16
) (
    input  wire logic              clk,
    input  wire logic              reset,
    oq_header_parser_mc_if.slave   bus
);

    localparam int c_PTR_W = $clog2(DESC_DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;
    localparam logic [c_CNT_W-1:0]           c_DEPTH   = c_CNT_W'(DESC_DEPTH);
    localparam logic [c_CNT_W-1:0]           c_CNT_ONE = c_CNT_W'(1);
    localparam logic [c_PTR_W-1:0]           c_PTR_ONE = c_PTR_W'(1);
    localparam logic [NUM_OUTPUT_QUEUES-1:0] c_Q_ONE   = NUM_OUTPUT_QUEUES'(1);
    localparam logic [ERR_CNT_WIDTH-1:0]     c_ERR_ONE = ERR_CNT_WIDTH'(1);

    localparam logic [1:0] c_WAIT_HDR  = 2'd0;
    localparam logic [1:0] c_WAIT_DATA = 2'd1;
    localparam logic [1:0] c_WAIT_EOP  = 2'd2;

    logic [1:0] r_state;
    logic [1:0] w_state_nxt;

    logic w_is_hdr;
    logic w_ctrl_zero;
    logic w_hdr_seen;
    logic w_missing;
    logic w_full;
    logic w_push;
    logic w_pop;
    logic w_rd;
    logic w_err;

    logic [NUM_OUTPUT_QUEUES-1:0]  w_hdr_mask;
    logic [PKT_BYTE_CNT_WIDTH-1:0] w_hdr_byte_len;
    logic [PKT_WORD_CNT_WIDTH-1:0] w_hdr_word_len;

    logic [NUM_OUTPUT_QUEUES-1:0]  r_mem_mask     [DESC_DEPTH];
    logic [PKT_BYTE_CNT_WIDTH-1:0] r_mem_byte_len [DESC_DEPTH];
    logic [PKT_WORD_CNT_WIDTH-1:0] r_mem_word_len [DESC_DEPTH];
    logic [c_PTR_W-1:0]            r_wr_ptr;
    logic [c_PTR_W-1:0]            r_rd_ptr;
    logic [c_CNT_W-1:0]            r_count;

    logic                          w_head_valid;
    logic [NUM_OUTPUT_QUEUES-1:0]  w_head_mask;
    logic [NUM_OUTPUT_QUEUES-1:0]  w_pending;
    logic [NUM_OUTPUT_QUEUES-1:0]  w_lowest;
    logic [NUM_OQ_WIDTH-1:0]       w_lowest_idx;
    logic                          w_drop;
    logic                          w_single;

    logic                          r_err_pulse;
    logic [ERR_CNT_WIDTH-1:0]      r_err_cnt;

    wire w_unused_data = &{1'b0, bus.in_data};

    assign w_is_hdr       = (bus.in_ctrl == IOQ_STAGE_NUM);
    assign w_ctrl_zero    = (bus.in_ctrl == '0);
    assign w_hdr_mask     = bus.in_data[DST_POS +: NUM_OUTPUT_QUEUES];
    assign w_hdr_byte_len = bus.in_data[BYTE_LEN_POS +: PKT_BYTE_CNT_WIDTH];
    assign w_hdr_word_len = bus.in_data[WORD_LEN_POS +: PKT_WORD_CNT_WIDTH];

    // ---------------- input FSM ----------------
    always_ff @(posedge clk) begin
        if (reset) r_state <= c_WAIT_HDR;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_WAIT_HDR: begin
                if (bus.in_wr && w_is_hdr)         w_state_nxt = c_WAIT_DATA;
                else if (bus.in_wr && w_ctrl_zero) w_state_nxt = c_WAIT_EOP;
            end
            c_WAIT_DATA: if (bus.in_wr && w_ctrl_zero)  w_state_nxt = c_WAIT_EOP;
            c_WAIT_EOP:  if (bus.in_wr && !w_ctrl_zero) w_state_nxt = c_WAIT_HDR;
            default:     w_state_nxt = c_WAIT_HDR;
        endcase
    end

    always_comb begin
        w_hdr_seen = 1'b0;
        w_missing  = 1'b0;
        if (r_state == c_WAIT_HDR && bus.in_wr) begin
            w_hdr_seen = w_is_hdr;
            w_missing  = w_ctrl_zero;
        end
    end

    // Overflow and empty mask can coincide on one header; it counts once.
    assign w_full = (r_count == c_DEPTH);
    assign w_push = w_hdr_seen && !w_full;
    assign w_err  = w_missing || (w_hdr_seen && (w_full || (w_hdr_mask == '0)));

    // ---------------- descriptor FIFO ----------------
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_mask[r_wr_ptr]     <= w_hdr_mask;
            r_mem_byte_len[r_wr_ptr] <= w_hdr_byte_len;
            r_mem_word_len[r_wr_ptr] <= w_hdr_word_len;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CNT_ONE;
                2'b01:   r_count <= r_count - c_CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    // ---------------- output side ----------------
    assign w_head_valid = (r_count != '0);
    assign w_head_mask  = r_mem_mask[r_rd_ptr];
    assign w_drop       = (w_head_mask == '0);
    assign w_rd         = bus.rd_desc && w_head_valid;

`ifdef OQ_HDR_PARSER_MCAST_EN
    // Pending is the head mask minus the copies already served; r_done clears
    // on every pop so a freshly visible head starts with its full mask.
    logic [NUM_OUTPUT_QUEUES-1:0] r_done;

    assign w_pending = w_head_mask & ~r_done;
    assign w_single  = ((w_pending & (w_pending - c_Q_ONE)) == '0);
    assign w_pop     = w_rd && (w_drop || w_single);

    always_ff @(posedge clk) begin
        if (reset || w_pop) r_done <= '0;
        else if (w_rd)      r_done <= r_done | w_lowest;
    end

    assign bus.desc_one_hot = w_head_valid ? w_lowest : '0;
`else
    assign w_pending = w_head_mask;
    assign w_single  = 1'b1;
    assign w_pop     = w_rd;

    assign bus.desc_one_hot = w_head_valid ? w_head_mask : '0;
`endif

    assign w_lowest = w_pending & (~w_pending + c_Q_ONE);

    always_comb begin
        w_lowest_idx = '0;
        for (int i = 0; i < NUM_OUTPUT_QUEUES; i++) begin
            if (w_lowest[i]) w_lowest_idx = w_lowest_idx | NUM_OQ_WIDTH'(i);
        end
    end

    assign bus.header_parser_rdy = !w_full;
    assign bus.desc_avail        = w_head_valid;
    assign bus.desc_dst_oq       = w_head_valid ? w_lowest_idx : '0;
    assign bus.desc_byte_len     = w_head_valid ? r_mem_byte_len[r_rd_ptr] : '0;
    assign bus.desc_word_len     = w_head_valid ? r_mem_word_len[r_rd_ptr] : '0;
    assign bus.desc_last         = w_head_valid && (w_drop || w_single);
    assign bus.desc_drop         = w_head_valid && w_drop;

    // ---------------- error reporting ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_err_pulse <= 1'b0;
            r_err_cnt   <= '0;
        end else begin
            r_err_pulse <= w_err;
            if (w_err && (r_err_cnt != '1)) r_err_cnt <= r_err_cnt + c_ERR_ONE;
        end
    end

    assign bus.err_pulse = r_err_pulse;
    assign bus.err_cnt   = r_err_cnt;

endmodule
`default_nettype wire

// File: tb/tb_oq_header_parser_mc.sv
`default_nettype none
// ============================================================================
// Module   : tb_oq_header_parser_mc
// Purpose  : Directed self-checking bench for oq_header_parser_mc; expected
//            values follow OQ_HDR_PARSER_MCAST_EN when it is defined.
// Revision : 1.0
// ============================================================================
module tb_oq_header_parser_mc;

    logic clk;
    logic reset;
    int   n_vec;
    int   n_err;

    oq_header_parser_mc_if bus ();

    oq_header_parser_mc dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] hdr(input logic [15:0] mask, input logic [10:0] bl,
                                        input logic [7:0] wl);
        return (64'(mask) << 48) | (64'(wl) << 32) | 64'(bl);
    endfunction

    // Called at a negedge; returns at the next negedge with the word consumed.
    task automatic send(input logic [7:0] ctrl, input logic [63:0] data);
        bus.in_wr   = 1'b1;
        bus.in_ctrl = ctrl;
        bus.in_data = data;
        @(negedge clk);
        bus.in_wr   = 1'b0;
        bus.in_ctrl = '0;
        bus.in_data = '0;
    endtask

    task automatic rd();
        bus.rd_desc = 1'b1;
        @(negedge clk);
        bus.rd_desc = 1'b0;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, ".avail"}, 32'(bus.desc_avail), 0);
        chk({tag, ".last"},  32'(bus.desc_last), 0);
        chk({tag, ".drop"},  32'(bus.desc_drop), 0);
        chk({tag, ".onehot"}, 32'(bus.desc_one_hot), 0);
        chk({tag, ".dst"},   32'(bus.desc_dst_oq), 0);
        chk({tag, ".blen"},  32'(bus.desc_byte_len), 0);
        chk({tag, ".wlen"},  32'(bus.desc_word_len), 0);
        chk({tag, ".rdy"},   32'(bus.header_parser_rdy), 1);
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        bus.in_wr = 1'b0; bus.in_ctrl = '0; bus.in_data = '0; bus.rd_desc = 1'b0;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;

        // Reset state
        chk_idle("rst");
        chk("rst.err_pulse", 32'(bus.err_pulse), 0);
        chk("rst.err_cnt",   32'(bus.err_cnt), 0);

        // Unicast 0x04, 60 bytes, 8 words
        send(8'hff, hdr(16'h0004, 11'd60, 8'd8));
        chk("uc.avail",  32'(bus.desc_avail), 1);
        chk("uc.dst",    32'(bus.desc_dst_oq), 2);
        chk("uc.onehot", 32'(bus.desc_one_hot), 32'h04);
        chk("uc.last",   32'(bus.desc_last), 1);
        chk("uc.drop",   32'(bus.desc_drop), 0);
        chk("uc.blen",   32'(bus.desc_byte_len), 60);
        chk("uc.wlen",   32'(bus.desc_word_len), 8);
        chk("uc.err",    32'(bus.err_pulse), 0);
        send(8'h00, 64'h1111);
        send(8'h01, 64'h2222);
        rd();
        chk("uc.empty", 32'(bus.desc_avail), 0);

        // Multicast 0x29
        send(8'hff, hdr(16'h0029, 11'd100, 8'd13));
        send(8'h00, 64'h0);
        send(8'h80, 64'h0);
        chk("mc.blen", 32'(bus.desc_byte_len), 100);
        chk("mc.wlen", 32'(bus.desc_word_len), 13);
`ifdef OQ_HDR_PARSER_MCAST_EN
        chk("mc0.dst",    32'(bus.desc_dst_oq), 0);
        chk("mc0.onehot", 32'(bus.desc_one_hot), 32'h01);
        chk("mc0.last",   32'(bus.desc_last), 0);
        rd();
        chk("mc1.dst",    32'(bus.desc_dst_oq), 3);
        chk("mc1.onehot", 32'(bus.desc_one_hot), 32'h08);
        chk("mc1.last",   32'(bus.desc_last), 0);
        rd();
        chk("mc2.dst",    32'(bus.desc_dst_oq), 5);
        chk("mc2.onehot", 32'(bus.desc_one_hot), 32'h20);
        chk("mc2.last",   32'(bus.desc_last), 1);
        rd();
`else
        chk("mc.dst",    32'(bus.desc_dst_oq), 0);
        chk("mc.onehot", 32'(bus.desc_one_hot), 32'h29);
        chk("mc.last",   32'(bus.desc_last), 1);
        rd();
`endif
        chk("mc.empty", 32'(bus.desc_avail), 0);

        // Missing header, then a proper packet
        send(8'h00, 64'hdead);
        chk("miss.err_pulse", 32'(bus.err_pulse), 1);
        chk("miss.err_cnt",   32'(bus.err_cnt), 1);
        chk("miss.avail",     32'(bus.desc_avail), 0);
        send(8'h01, 64'hbeef);
        chk("miss.err_clr",   32'(bus.err_pulse), 0);
        send(8'hff, hdr(16'h0080, 11'd64, 8'd8));
        chk("post.dst",    32'(bus.desc_dst_oq), 7);
        chk("post.onehot", 32'(bus.desc_one_hot), 32'h80);
        chk("post.blen",   32'(bus.desc_byte_len), 64);
        send(8'h00, 64'h0);
        send(8'h01, 64'h0);
        rd();
        chk("post.empty", 32'(bus.desc_avail), 0);

        // Empty in-range mask (bits above the queue count are ignored)
        send(8'hff, hdr(16'hff00, 11'd42, 8'd6));
        chk("drop.avail",  32'(bus.desc_avail), 1);
        chk("drop.drop",   32'(bus.desc_drop), 1);
        chk("drop.last",   32'(bus.desc_last), 1);
        chk("drop.onehot", 32'(bus.desc_one_hot), 0);
        chk("drop.dst",    32'(bus.desc_dst_oq), 0);
        chk("drop.err",    32'(bus.err_pulse), 1);
        chk("drop.cnt",    32'(bus.err_cnt), 2);
        send(8'h00, 64'h0);
        send(8'h01, 64'h0);
        rd();
        chk("drop.empty", 32'(bus.desc_avail), 0);

        // Fill the FIFO, then overflow
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("fill%0d.rdy", i), 32'(bus.header_parser_rdy), 1);
            send(8'hff, hdr(16'(1 << i), 11'(10 + i), 8'(i + 1)));
            send(8'h00, 64'h0);
            send(8'h01, 64'h0);
        end
        chk("fill.rdy", 32'(bus.header_parser_rdy), 0);
        send(8'hff, hdr(16'h0001, 11'd99, 8'd99));
        chk("ovf.err", 32'(bus.err_pulse), 1);
        chk("ovf.cnt", 32'(bus.err_cnt), 3);
        send(8'h00, 64'h0);
        send(8'h01, 64'h0);
        bus.rd_desc = 1'b1;
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("drain%0d.avail", i), 32'(bus.desc_avail), 1);
            chk($sformatf("drain%0d.dst", i),   32'(bus.desc_dst_oq), 32'(i));
            chk($sformatf("drain%0d.blen", i),  32'(bus.desc_byte_len), 32'(10 + i));
            chk($sformatf("drain%0d.wlen", i),  32'(bus.desc_word_len), 32'(i + 1));
            @(negedge clk);
        end
        bus.rd_desc = 1'b0;
        chk("drain.empty", 32'(bus.desc_avail), 0);
        chk("drain.rdy",   32'(bus.header_parser_rdy), 1);
        chk("drain.err",   32'(bus.err_pulse), 0);

        // Reset mid-packet
        send(8'hff, hdr(16'h0002, 11'd33, 8'd5));
        chk("mid.avail", 32'(bus.desc_avail), 1);
        send(8'h00, 64'h0);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk_idle("mid.rst");
        chk("mid.rst.err_cnt", 32'(bus.err_cnt), 0);
        send(8'h00, 64'h0);
        chk("mid.miss.err", 32'(bus.err_pulse), 1);
        chk("mid.miss.cnt", 32'(bus.err_cnt), 1);
        chk("mid.miss.avail", 32'(bus.desc_avail), 0);
        send(8'h01, 64'h0);
        send(8'hff, hdr(16'h0010, 11'd200, 8'd25));
        chk("mid.new.dst",  32'(bus.desc_dst_oq), 4);
        chk("mid.new.blen", 32'(bus.desc_byte_len), 200);
        chk("mid.new.wlen", 32'(bus.desc_word_len), 25);
        chk("mid.new.last", 32'(bus.desc_last), 1);
        rd();
        chk("mid.new.empty", 32'(bus.desc_avail), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
